sc_fifo_reader: RTL

- Read-side companion to sc_fifo. Drains the FIFO's registered rd/data_out port and re-presents the words as a valid/ready stream for downstream consumers.
- Holds a 3-entry output buffer so full throughput is reached with no combinational path from m_ready to fifo_rd.
- Provides a flush input that clears both the FIFO and the in-flight/buffered words in one cycle.

---
 rtl/sc_fifo_pkg.sv | 18 +
 rtl/sc_fifo_rd_buf.sv | 70 +++++++
 rtl/sc_fifo_reader.sv | 71 +++++++
 3 files changed

// File: rtl/sc_fifo_pkg.sv
// Shared constants and types for the sc_fifo family (FIFO, reader, writer-side blocks).
package sc_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 12;
    localparam int unsigned RD_BUF_DEPTH   = 3;

    // Pointer into the reader output buffer; only values 0..RD_BUF_DEPTH-1 are used.
    typedef logic [1:0] rd_buf_ptr_t;

    // Advance a buffer pointer, wrapping after the last entry.
    function automatic rd_buf_ptr_t rd_buf_ptr_inc(input rd_buf_ptr_t ptr);
        rd_buf_ptr_t max_ptr;
        max_ptr = rd_buf_ptr_t'(RD_BUF_DEPTH - 1);
        return (ptr == max_ptr) ? rd_buf_ptr_t'(0) : ptr + rd_buf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/sc_fifo_rd_buf.sv
// Three-entry circular buffer holding words drained from sc_fifo until accepted downstream.
module sc_fifo_rd_buf
    import sc_fifo_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [1:0]            occ,
    output logic [data_width-1:0] head_data
);

    logic [data_width-1:0] mem_q [RD_BUF_DEPTH];
    logic [data_width-1:0] mem_d [RD_BUF_DEPTH];
    rd_buf_ptr_t           wr_ptr_q, wr_ptr_d;
    rd_buf_ptr_t           rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;

    // Next-state: flush empties the buffer; otherwise push/pop move pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = rd_buf_ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = rd_buf_ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // The issue rule guarantees a slot for every in-flight word, so a full buffer never gets pushed.
    assert property (@(posedge clk) disable iff (reset) push |-> (occ_q != 2'd3));

    assign occ       = occ_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sc_fifo_reader.sv
// Drains sc_fifo's registered read port into a valid/ready stream via a 3-entry buffer.
module sc_fifo_reader
    import sc_fifo_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH_DEF,
    parameter int unsigned fifo_depth = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  fifo_rd,
    input  logic [data_width-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic [fifo_depth:0]   fifo_use_words,
    output logic                  fifo_clear,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [data_width-1:0] m_data,
    input  logic                  m_ready,
    output logic [31:0]           rd_count,
    output logic [fifo_depth+1:0] level_total
);

    localparam int unsigned LvlW = fifo_depth + 2;

    logic        inflight_q, inflight_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic [1:0]  occ;
    logic [2:0]  occ_sum;
    logic        push;
    logic        pop;

    // Issue, capture and pop decisions; m_ready never reaches fifo_rd.
    always_comb begin
        occ_sum    = {1'b0, occ} + {2'b00, inflight_q};
        fifo_rd    = !reset && !flush && !fifo_empty && (occ_sum < 3'd3);
        fifo_clear = flush && !reset;
        push       = inflight_q && !flush;
        pop        = m_valid && m_ready && !flush;
        inflight_d = fifo_rd;
        rd_count_d = pop ? rd_count_q + 32'd1 : rd_count_q;
    end

    // Inflight flag and delivered-word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
        end
    end

    sc_fifo_rd_buf #(
        .data_width(data_width)
    ) u_rd_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(fifo_data_out),
        .pop      (pop),
        .flush    (flush),
        .occ      (occ),
        .head_data(m_data)
    );

    assign m_valid     = (occ != 2'd0);
    assign rd_count    = rd_count_q;
    assign level_total = LvlW'(fifo_use_words) + LvlW'(occ_sum);

endmodule
